// File: rtl/pool_pkg.sv
// Shared types for the 2x2 pooling window producer: pixel type, FSM states, index width helper.
// Pure declarations, no logic, no latency, no flow control.
package pool_pkg;

    localparam int POOL_DATA_W = 8;

    typedef logic [POOL_DATA_W-1:0] pix_t;

    typedef enum logic [1:0] {
        ROW_EVEN = 2'd0,
        ROW_ODD  = 2'd1,
        WIN_HOLD = 2'd2
    } state_t;

    // Counter width that stays legal (>=1 bit) for a dimension of size n.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-row pixel store: one write port, two async reads of the column pair holding rd_col.
// Write lands on the clock edge, reads are combinational; no flow control.
module pool_line_buf
    import pool_pkg::*;
#(
    parameter int DATA_W = POOL_DATA_W,
    parameter int IMG_W  = 16
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [idx_w(IMG_W)-1:0]   wr_col,
    input  logic [DATA_W-1:0]         wr_dat,
    input  logic [idx_w(IMG_W)-1:0]   rd_col,
    output logic [DATA_W-1:0]         rd_lo_dat,
    output logic [DATA_W-1:0]         rd_hi_dat
);

    localparam int COL_W = idx_w(IMG_W);

    logic [DATA_W-1:0] mem_q [IMG_W];
    logic [COL_W-1:0]  lo_col;
    logic [COL_W-1:0]  hi_col;

    // Pair addressing keeps both reads in range even for non power-of-two widths.
    always_comb begin
        lo_col = rd_col & ~COL_W'(1);
        hi_col = lo_col | COL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_col] <= wr_dat;
        end
    end

    assign rd_lo_dat = mem_q[lo_col];
    assign rd_hi_dat = mem_q[hi_col];

endmodule

// File: rtl/pool_window_gen.sv
// Raster pixel stream to non-overlapping 2x2 windows; window valid one cycle after its 4th pixel.
// Stalls the pixel input while a window waits for win_ready. POOL_WIN_LAST_EN adds win_last.
module pool_window_gen
    import pool_pkg::*;
#(
    parameter int DATA_W = POOL_DATA_W,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [DATA_W-1:0] win0,
    output logic [DATA_W-1:0] win1,
    output logic [DATA_W-1:0] win2,
    output logic [DATA_W-1:0] win3,
    output logic              win_valid,
    input  logic              win_ready,
`ifdef POOL_WIN_LAST_EN
    output logic              win_last,
`endif
    output logic              frame_done
);

    localparam int COL_W = idx_w(IMG_W);
    localparam int ROW_W = idx_w(IMG_H);

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [DATA_W-1:0] prev_pix_q, prev_pix_d;
    logic [DATA_W-1:0] win0_q, win0_d;
    logic [DATA_W-1:0] win1_q, win1_d;
    logic [DATA_W-1:0] win2_q, win2_d;
    logic [DATA_W-1:0] win3_q, win3_d;
    logic              win_valid_q, win_valid_d;
    logic              frame_done_q, frame_done_d;
`ifdef POOL_WIN_LAST_EN
    logic              win_last_q, win_last_d;
`endif

    logic              pix_xfer;
    logic              win_xfer;
    logic              col_last;
    logic              row_last;
    logic              lb_wr_en;
    logic [DATA_W-1:0] lb_lo_dat;
    logic [DATA_W-1:0] lb_hi_dat;

    assign pix_ready = (state_q != WIN_HOLD);
    assign pix_xfer  = pix_valid && pix_ready;
    assign win_xfer  = win_valid_q && win_ready;
    assign col_last  = (col_q == COL_W'(IMG_W - 1));
    assign row_last  = (row_q == ROW_W'(IMG_H - 1));
    assign lb_wr_en  = pix_xfer && (state_q == ROW_EVEN);

    pool_line_buf #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W)
    ) u_line_buf (
        .clk       (clk),
        .wr_en     (lb_wr_en),
        .wr_col    (col_q),
        .wr_dat    (pix_in),
        .rd_col    (col_q),
        .rd_lo_dat (lb_lo_dat),
        .rd_hi_dat (lb_hi_dat)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pix_xfer) begin
            col_d = col_last ? '0 : col_q + COL_W'(1);
            if (col_last) begin
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        prev_pix_d   = prev_pix_q;
        win0_d       = win0_q;
        win1_d       = win1_q;
        win2_d       = win2_q;
        win3_d       = win3_q;
        win_valid_d  = win_valid_q;
        frame_done_d = 1'b0;
`ifdef POOL_WIN_LAST_EN
        win_last_d   = win_last_q;
`endif
        case (state_q)
            ROW_EVEN: begin
                if (pix_xfer && col_last) begin
                    state_d = ROW_ODD;
                end
            end
            ROW_ODD: begin
                if (pix_xfer) begin
                    if (!col_q[0]) begin
                        prev_pix_d = pix_in;
                    end else begin
                        win0_d      = lb_lo_dat;
                        win1_d      = lb_hi_dat;
                        win2_d      = prev_pix_q;
                        win3_d      = pix_in;
                        win_valid_d = 1'b1;
`ifdef POOL_WIN_LAST_EN
                        win_last_d  = row_last && col_last;
`endif
                        state_d     = WIN_HOLD;
                    end
                end
            end
            WIN_HOLD: begin
                // Counters already advanced past the closing pixel: col 0 means row end,
                // and row 0 with col 0 can only follow the frame's final pixel.
                if (win_xfer) begin
                    win_valid_d  = 1'b0;
`ifdef POOL_WIN_LAST_EN
                    win_last_d   = 1'b0;
`endif
                    state_d      = (col_q == '0) ? ROW_EVEN : ROW_ODD;
                    frame_done_d = (col_q == '0) && (row_q == '0);
                end
            end
            default: begin
                state_d = ROW_EVEN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ROW_EVEN;
            col_q        <= '0;
            row_q        <= '0;
            prev_pix_q   <= '0;
            win0_q       <= '0;
            win1_q       <= '0;
            win2_q       <= '0;
            win3_q       <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef POOL_WIN_LAST_EN
            win_last_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            prev_pix_q   <= prev_pix_d;
            win0_q       <= win0_d;
            win1_q       <= win1_d;
            win2_q       <= win2_d;
            win3_q       <= win3_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
`ifdef POOL_WIN_LAST_EN
            win_last_q   <= win_last_d;
`endif
        end
    end

    assign win0       = win0_q;
    assign win1       = win1_q;
    assign win2       = win2_q;
    assign win3       = win3_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
`ifdef POOL_WIN_LAST_EN
    assign win_last   = win_last_q;
`endif

endmodule

// File: tb/tb_pool_window_gen.sv
// Scoreboard bench for pool_window_gen on a 4x4 map: expected windows queued at issue, monitor pops on handshake.
module tb_pool_window_gen;
    import pool_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    pix_t pix_in;
    logic pix_valid;
    logic pix_ready;
    pix_t win0, win1, win2, win3;
    logic win_valid;
    logic win_ready;
    logic frame_done;
`ifdef POOL_WIN_LAST_EN
    logic win_last;
`endif

    pool_window_gen #(
        .DATA_W (8),
        .IMG_W  (4),
        .IMG_H  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .win0       (win0),
        .win1       (win1),
        .win2       (win2),
        .win3       (win3),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
`ifdef POOL_WIN_LAST_EN
        .win_last   (win_last),
`endif
        .frame_done (frame_done)
    );

    typedef struct {
        int w0;
        int w1;
        int w2;
        int w3;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   passes  = 0;
    int   fd_seen = 0;

    // Windows of a 4x4 frame carrying pixels 1..16 in raster order.
    int tbl [4][4] = '{'{1, 2, 5, 6}, '{3, 4, 7, 8}, '{9, 10, 13, 14}, '{11, 12, 15, 16}};

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, got, want);
    endtask

    // Monitor: samples on the falling edge, i.e. the values the next rising edge will act on.
    logic fd_pending = 1'b0;
    exp_t e;
    always @(negedge clk) begin
        if (!rst_n) begin
            fd_pending = 1'b0;
        end else begin
            if (frame_done || fd_pending) check("frame_done_pulse", int'(frame_done), int'(fd_pending));
            if (frame_done) fd_seen++;
            fd_pending = 1'b0;
            if (win_valid && win_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL win_unexpected: got %0d,%0d,%0d,%0d expected no window",
                             win0, win1, win2, win3);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (int'(win0) == e.w0 && int'(win1) == e.w1 &&
                        int'(win2) == e.w2 && int'(win3) == e.w3) passes++;
                    else $display("FAIL window: got %0d,%0d,%0d,%0d expected %0d,%0d,%0d,%0d",
                                  win0, win1, win2, win3, e.w0, e.w1, e.w2, e.w3);
`ifdef POOL_WIN_LAST_EN
                    check("win_last", int'(win_last), int'(e.last));
`endif
                    fd_pending = e.last;
                end
            end
        end
    end

    task automatic push_frame(input int off);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{tbl[k][0] + off, tbl[k][1] + off, tbl[k][2] + off, tbl[k][3] + off, (k == 3)});
        end
    endtask

    task automatic send_pix(input int v, input int gap);
        int n;
        pix_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        pix_in    = pix_t'(v);
        pix_valid = 1'b1;
        n = 0;
        while (!pix_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!pix_ready) begin
            checks++;
            $display("FAIL pix_ready_timeout: got 0 expected 1 for pixel %0d", v);
            pix_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
    endtask

    task automatic send_frame(input int off, input int gap);
        for (int i = 0; i < 16; i++) send_pix(off + i + 1, gap);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || win_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Holds win_ready low on the first window of the frame at offset 16 and checks it stays put.
    task automatic hold_check();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!win_valid && n < 200);
        if (!win_valid) begin
            checks++;
            $display("FAIL hold_wait_timeout: got win_valid 0 expected 1");
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (i > 0) @(negedge clk);
                checks++;
                if (win0 == 8'd17 && win1 == 8'd18 && win2 == 8'd21 && win3 == 8'd22 && win_valid) passes++;
                else $display("FAIL hold_window: got %0d,%0d,%0d,%0d v=%0d expected 17,18,21,22 v=1",
                              win0, win1, win2, win3, win_valid);
                check("hold_pix_ready", int'(pix_ready), 0);
            end
        end
        @(posedge clk);
        #1;
        win_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_in    = '0;
        win_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("rst_win_valid", int'(win_valid), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_pix_ready", int'(pix_ready), 1);
        check("rst_win0", int'(win0), 0);
        check("rst_win1", int'(win1), 0);
        check("rst_win2", int'(win2), 0);
        check("rst_win3", int'(win3), 0);
`ifdef POOL_WIN_LAST_EN
        check("rst_win_last", int'(win_last), 0);
`endif

        // Frame 1..16, consumer always ready.
        push_frame(0);
        send_frame(0, 0);
        drain();

        // Frame 17..32 with first window stalled, then 33..48 back-to-back with input gaps.
        win_ready = 1'b0;
        push_frame(16);
        fork
            send_frame(16, 0);
            hold_check();
        join
        push_frame(32);
        send_frame(32, 1);
        drain();

        // Abort: six pixels leave a window pending, reset must drop it silently.
        win_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_pix(100 + i, 0);
        @(posedge clk);
        #1;
        check("abort_window_pending", int'(win_valid), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_win_valid", int'(win_valid), 0);
        check("abort_pix_ready", int'(pix_ready), 1);
        win_ready = 1'b1;
        @(posedge clk);
        #1;
        check("abort_frame_done", int'(frame_done), 0);

        // Fresh frame after the abort.
        push_frame(0);
        send_frame(0, 0);
        drain();

        check("frame_done_count", fd_seen, 4);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pool_window_gen.md
Name: pool_window_gen

Overview:
Producer side of the 2x2 max-pooling stage: accepts a raster-scanned feature-map pixel stream and emits complete non-overlapping 2x2 windows (stride 2) as four parallel operands plus a valid strobe for the pooling unit. It buffers one even row in a line buffer, pairs it with the following odd row, and applies backpressure upstream while a window waits to be taken. Sits between the conv/activation output stream and the max-pooling comparator.

Parameters:
DATA_W, 8, pixel width in bits (matches pooling operand width)
IMG_W, 16, feature-map width in pixels; even, >=2
IMG_H, 16, feature-map height in rows; even, >=2

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
pix_in  in  DATA_W  input pixel, raster order, row 0 col 0 first
pix_valid  in  1  pix_in valid
pix_ready  out  1  block accepts pix_in this cycle; transfer = pix_valid && pix_ready
win0  out  DATA_W  window top-left (row r-1, col c-1)
win1  out  DATA_W  window top-right (row r-1, col c)
win2  out  DATA_W  window bottom-left (row r, col c-1)
win3  out  DATA_W  window bottom-right (row r, col c)
win_valid  out  1  window operands valid; drives pooling enable
win_ready  in  1  consumer takes window; transfer = win_valid && win_ready
frame_done  out  1  one-cycle pulse when last window of frame is taken

Behaviour:
- Reset (rst_n=0 at clk edge): col=0, row=0, state=ROW_EVEN, win0..win3=0, win_valid=0, frame_done=0, prev_pix=0. Line buffer contents not reset (don't-care). pix_ready comb = (state != WIN_HOLD).
- Counters: col 0..IMG_W-1, row 0..IMG_H-1; advance only on pixel transfer; col wraps to 0 and increments row; row wraps to 0 after IMG_H-1.
- States: ROW_EVEN, ROW_ODD, WIN_HOLD.
- ROW_EVEN: on transfer, linebuf[col] <= pix_in. At col=IMG_W-1 -> ROW_ODD.
- ROW_ODD, even col: on transfer, prev_pix <= pix_in.
- ROW_ODD, odd col: on transfer, win0<=linebuf[col-1], win1<=linebuf[col], win2<=prev_pix, win3<=pix_in, win_valid<=1 -> WIN_HOLD.
- Latency: win_valid rises the cycle after the 4th window pixel is accepted.
- WIN_HOLD: pix_ready=0; win0..3, win_valid stable until transfer. On transfer: win_valid<=0; next state ROW_EVEN if the accepted pixel was col=IMG_W-1 (row end), else ROW_ODD. If it closed row IMG_H-1 col IMG_W-1, frame_done=1 for exactly that next cycle.
- Counter advance for the window-closing pixel occurs at pixel transfer, not at window transfer.
- No concurrent pixel and window transfer: pix_ready is 0 throughout WIN_HOLD, including the cycle win_ready is high.
- pix_valid gaps: state and counters hold; no timeout.
- win_ready high without win_valid: ignored.
- Back-to-back frames: counters wrap to 0; no idle cycle required beyond the window handshake.
- Reset mid-frame: partial frame discarded, no frame_done, pending window dropped (win_valid=0 next cycle).
- Throughput: IMG_W*IMG_H pixel cycles + (IMG_W/2)*(IMG_H/2) window cycles per frame, minimum.

Optional Feature:
POOL_WIN_LAST_EN: when defined, adds output win_last (1 bit), asserted with win_valid and held stable for the frame's final window only; reset 0. frame_done unchanged. When undefined, port and logic absent; behaviour otherwise identical.

Decomposition:
- Package pool_pkg: DATA_W default, state enum (ROW_EVEN, ROW_ODD, WIN_HOLD), pixel typedef pix_t.
- One sub-module: pool_line_buf (IMG_W x DATA_W, one write port, two asynchronous read ports at col-1 and col).

Test Plan:
- IMG_W=4, IMG_H=2, pixels 1..8, win_ready=1 -> windows (1,2,5,6) then (3,4,7,8); frame_done pulses once, the cycle after the second window transfer.
- Same stream, win_ready=0 for 3 cycles on first window -> win0..3=(1,2,5,6) stable, win_valid=1, pix_ready=0 for those cycles; stream resumes after transfer.
- IMG_W=4, IMG_H=4, pixels 1..16 with pix_valid toggling every other cycle -> windows (1,2,5,6),(3,4,7,8),(9,10,13,14),(11,12,15,16) in order.
- Two consecutive frames (1..8 then 9..16, W=4,H=2) -> second frame windows (9,10,13,14),(11,12,15,16); two frame_done pulses.
- rst_n=0 after 5 pixels of frame, then fresh 1..8 -> no window from the aborted frame, no frame_done from it, correct windows for the new frame.
- POOL_WIN_LAST_EN defined, W=4,H=4 -> win_last=1 only with window (11,12,15,16).
